ddr2_bit_tap_calib_0: RTL and testbench

DDR2_BIT_TAP_CALIB_0 -- requirements
Module: ddr2_bit_tap_calib_0

---
 rtl/ddr2_bit_tap_calib_0_pkg.sv | 29 ++
 rtl/ddr2_tap_center_calc_0.sv | 28 ++
 rtl/ddr2_bit_tap_calib_0.sv | 173 +++++++++++++++++
 tb/tb_ddr2_bit_tap_calib_0.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_bit_tap_calib_0_pkg.sv
// Shared types and constants for the per-bit DQ IDELAY tap calibration block.
package ddr2_bit_tap_calib_0_pkg;

  localparam int TAP_W       = 6;
  localparam int BIT_CNT_W   = 3;
  localparam int CH_WAIT_CYC = 3;
  localparam int FILT_DEPTH  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    INC,
    DEC,
    CHAN,
    CH_WAIT,
    DONE
  } calib_state_e;

  // Majority vote over the filter window; an even split keeps the current reference.
  function automatic logic majority4(input logic [FILT_DEPTH-1:0] win, input logic tie);
    int unsigned ones;
    ones = $countones(win);
    if (ones > 2) return 1'b1;
    if (ones < 2) return 1'b0;
    return tie;
  endfunction

endpackage

// File: rtl/ddr2_tap_center_calc_0.sv
// Window-centre arithmetic: midpoint of the two recorded data-eye edges.
module ddr2_tap_center_calc_0
  import ddr2_bit_tap_calib_0_pkg::*;
#(
  parameter int TAP_MAX = 63
) (
  input  logic [TAP_W-1:0] e1,
  input  logic [TAP_W-1:0] e2,
  input  logic             e1_v,
  input  logic             e2_v,
  output logic [TAP_W-1:0] center,
  output logic             no_edge
);

  localparam logic [TAP_W-1:0] MID_TAP = TAP_W'(TAP_MAX >> 1);

  logic [TAP_W-1:0] span;

  // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
  always_comb begin
    span    = e2 - e1;
    no_edge = !e1_v;
    if (no_edge)   center = MID_TAP;
    else if (e2_v) center = e1 + (span >> 1);
    else           center = e1;
  end

endmodule

// File: rtl/ddr2_bit_tap_calib_0.sv
// Per-bit IDELAY tap calibration: sweep taps, find two eye edges, back off to the centre.
// Optional DDR2_CALIB_FILTER_EN: majority-of-4 sample filter with a 3-cycle longer settle.
module ddr2_bit_tap_calib_0
  import ddr2_bit_tap_calib_0_pkg::*;
#(
  parameter int TAP_MAX    = 63,
  parameter int SETTLE_CYC = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 calib_start,
  input  logic                 dq_data,
  input  logic                 calib_done,
  output logic                 ctrl_calib_start,
  output logic                 dlyinc,
  output logic                 dlyce,
  output logic                 chan_done,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [TAP_W-1:0]     center_tap,
  output logic                 tap_calib_done,
  output logic                 tap_error
);

`ifdef DDR2_CALIB_FILTER_EN
  localparam int SETTLE_LEN = SETTLE_CYC + FILT_DEPTH - 1;
`else
  localparam int SETTLE_LEN = SETTLE_CYC;
`endif
  localparam int               CNT_W   = $clog2(SETTLE_LEN + CH_WAIT_CYC + 1);
  localparam logic [TAP_W-1:0] TAP_TOP = TAP_W'(TAP_MAX);

  calib_state_e     state_q;
  logic [TAP_W-1:0] tap_q, e1_q, e2_q, center;
  logic             e1_v_q, e2_v_q, ref_q, no_edge;
  logic [CNT_W-1:0] cnt_q;
  logic             samp_s, edge_s;

`ifdef DDR2_CALIB_FILTER_EN
  logic [FILT_DEPTH-2:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= {hist_q[FILT_DEPTH-3:0], dq_data};
  end

  assign samp_s = majority4({hist_q, dq_data}, ref_q);
`else
  assign samp_s = dq_data;
`endif

  assign edge_s = (samp_s != ref_q);

  ddr2_tap_center_calc_0 #(.TAP_MAX(TAP_MAX)) u_center (
    .e1     (e1_q),
    .e2     (e2_q),
    .e1_v   (e1_v_q),
    .e2_v   (e2_v_q),
    .center (center),
    .no_edge(no_edge)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      tap_q            <= '0;
      e1_q             <= '0;
      e2_q             <= '0;
      e1_v_q           <= 1'b0;
      e2_v_q           <= 1'b0;
      ref_q            <= 1'b0;
      cnt_q            <= '0;
      ctrl_calib_start <= 1'b0;
      dlyinc           <= 1'b0;
      dlyce            <= 1'b0;
      chan_done        <= 1'b0;
      bit_cnt          <= '0;
      center_tap       <= '0;
      tap_calib_done   <= 1'b0;
      tap_error        <= 1'b0;
    end else begin
      dlyce     <= 1'b0;
      dlyinc    <= 1'b0;
      chan_done <= 1'b0;
      case (state_q)
        IDLE: if (calib_start) begin
          ctrl_calib_start <= 1'b1;
          tap_q            <= '0;
          cnt_q            <= '0;
          state_q          <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_LEN - 1)) state_q <= SAMPLE;
          else                                 cnt_q   <= cnt_q + 1'b1;
        end
        SAMPLE: begin
          if (tap_q == '0) begin
            ref_q   <= samp_s;
            e1_v_q  <= 1'b0;
            e2_v_q  <= 1'b0;
            dlyce   <= 1'b1;
            dlyinc  <= 1'b1;
            state_q <= INC;
          end else if (edge_s && e1_v_q) begin
            e2_q    <= tap_q;
            e2_v_q  <= 1'b1;
            state_q <= DEC;
          end else if (tap_q == TAP_TOP) begin
            // Sweep exhausted: the top tap closes an open window, or the bit has no edge at all.
            if (no_edge && !edge_s) begin
              tap_error <= 1'b1;
            end else begin
              if (!e1_v_q) begin
                e1_q   <= tap_q;
                e1_v_q <= 1'b1;
              end
              e2_q   <= TAP_TOP;
              e2_v_q <= 1'b1;
            end
            state_q <= DEC;
          end else begin
            if (edge_s) begin
              e1_q   <= tap_q;
              e1_v_q <= 1'b1;
              ref_q  <= samp_s;
            end
            dlyce   <= 1'b1;
            dlyinc  <= 1'b1;
            state_q <= INC;
          end
        end
        INC: begin
          tap_q   <= tap_q + 1'b1;
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        DEC: begin
          if (tap_q > center) begin
            tap_q <= tap_q - 1'b1;
            dlyce <= 1'b1;
          end else begin
            chan_done <= 1'b1;
            state_q   <= CHAN;
          end
        end
        CHAN: begin
          center_tap <= center;
          bit_cnt    <= bit_cnt + 1'b1;
          tap_q      <= '0;
          cnt_q      <= '0;
          state_q    <= CH_WAIT;
        end
        CH_WAIT: begin
          if (cnt_q == CNT_W'(CH_WAIT_CYC - 1)) begin
            cnt_q <= '0;
            if (calib_done) begin
              tap_calib_done   <= 1'b1;
              ctrl_calib_start <= 1'b0;
              state_q          <= DONE;
            end else begin
              state_q <= SETTLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_bit_tap_calib_0.sv
// Bench for ddr2_bit_tap_calib_0: IDELAY/DQ environment model plus per-bit eye-scan reference.
module tb_ddr2_bit_tap_calib_0;
  import ddr2_bit_tap_calib_0_pkg::*;

  localparam int TAP_MAX    = 63;
  localparam int SETTLE_CYC = 7;
`ifdef DDR2_CALIB_FILTER_EN
  localparam int S_EFF = SETTLE_CYC + 3;
`else
  localparam int S_EFF = SETTLE_CYC;
`endif

  logic clk = 1'b0;
  logic reset, calib_start, dq_data, calib_done;
  logic ctrl_calib_start, dlyinc, dlyce, chan_done, tap_calib_done, tap_error;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [TAP_W-1:0]     center_tap;

  ddr2_bit_tap_calib_0 #(.TAP_MAX(TAP_MAX), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk             (clk),
    .reset           (reset),
    .calib_start     (calib_start),
    .dq_data         (dq_data),
    .calib_done      (calib_done),
    .ctrl_calib_start(ctrl_calib_start),
    .dlyinc          (dlyinc),
    .dlyce           (dlyce),
    .chan_done       (chan_done),
    .bit_cnt         (bit_cnt),
    .center_tap      (center_tap),
    .tap_calib_done  (tap_calib_done),
    .tap_error       (tap_error)
  );

  always #5 clk = ~clk;

  // Eye pattern of one DQ bit: starting value v0, toggles at taps a1 and a2 (0 = no toggle).
  typedef struct {
    bit v0;
    int a1;
    int a2;
  } pat_t;

  pat_t pats[8];
  int   tend[8], ctr_exp[8];
  bit   err_exp[8];

  int errors = 0, checks = 0;
  bit track = 1'b0;
  int cyc, ch, chans, inc_n, dec_n, exp_chan_cyc, done_cyc, last, glitch_at;
  int phys[8];
  bit run, done_m, err_sticky, post_chan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit dq_at(input pat_t p, input int t);
    bit v = p.v0;
    if (p.a1 > 0 && t >= p.a1) v = ~v;
    if (p.a2 > 0 && t >= p.a2) v = ~v;
    return v;
  endfunction

  // Scan the eye from tap 0 upward: first toggle opens, second toggle (or the top tap) closes.
  function automatic void model_bit(input pat_t p, output int t_end, output int ctr, output bit err);
    bit rf = dq_at(p, 0);
    int e1 = -1;
    err = 1'b0;
    for (int t = 1; t <= TAP_MAX; t++) begin
      if (dq_at(p, t) != rf) begin
        if (e1 < 0) begin
          e1 = t;
          rf = dq_at(p, t);
        end else begin
          t_end = t;
          ctr   = e1 + (t - e1) / 2;
          return;
        end
      end
    end
    t_end = TAP_MAX;
    if (e1 >= 0) ctr = e1 + (TAP_MAX - e1) / 2;
    else begin
      ctr = TAP_MAX / 2;
      err = 1'b1;
    end
  endfunction

  function automatic pat_t rand_pat();
    pat_t p;
    p.v0 = bit'($urandom_range(0, 1));
    p.a1 = int'($urandom_range(0, TAP_MAX));
    p.a2 = 0;
    if (p.a1 > 0 && p.a1 < TAP_MAX && $urandom_range(0, 3) != 0)
      p.a2 = int'($urandom_range(p.a1 + 1, TAP_MAX));
    return p;
  endfunction

  // Cycles from a bit's first settle cycle to its channel-done cycle.
  function automatic int bit_cycles(input int k);
    return tend[k] * (S_EFF + 2) + S_EFF + (tend[k] - ctr_exp[k]) + 2;
  endfunction

  task automatic prepare();
    for (int k = 0; k < 8; k++) begin
      model_bit(pats[k], tend[k], ctr_exp[k], err_exp[k]);
      phys[k] = 0;
    end
    cyc = 0; ch = 0; chans = 0; inc_n = 0; dec_n = 0; exp_chan_cyc = -1;
    done_cyc = 0; last = 0; glitch_at = -1;
    run = 1'b0; done_m = 1'b0; err_sticky = 1'b0; post_chan = 1'b0;
    calib_done = 1'b0;
    dq_data = dq_at(pats[0], 0);
    track = 1'b1;
  endtask

  // One cycle of environment + comparison, run 3 time units after each rising edge.
  task automatic tick();
    logic [3:0] ctl_act, ctl_exp;
    cyc++;
    if (!run && !done_m && calib_start) begin
      run = 1'b1;
      exp_chan_cyc = cyc + bit_cycles(0);
    end
    if (done_cyc != 0 && cyc == done_cyc) begin
      run    = 1'b0;
      done_m = 1'b1;
    end
    if (post_chan) begin
      post_chan = 1'b0;
      check("center_tap", center_tap, ctr_exp[last]);
      check("bit_cnt", bit_cnt, (last + 1) % 8);
    end
    ctl_act = {ctrl_calib_start, tap_calib_done, dlyinc & ~dlyce, (dlyce | chan_done) & ~run};
    ctl_exp = {run, done_m, 2'b00};
    check("ctl", ctl_act, ctl_exp);
    if (dlyce) begin
      if (dlyinc) begin
        phys[ch]++;
        inc_n++;
`ifdef DDR2_CALIB_FILTER_EN
        if (ch == 0 && phys[0] == 5 && pats[0].a1 == 10) glitch_at = cyc + S_EFF + 1;
`endif
      end else begin
        phys[ch]--;
        dec_n++;
      end
      check("tap_range", (phys[ch] >= 0 && phys[ch] <= TAP_MAX), 1);
    end
    if (chan_done && run) begin
      check("chan_time", cyc, exp_chan_cyc);
      check("inc_pulses", inc_n, tend[ch]);
      check("dec_pulses", dec_n, tend[ch] - ctr_exp[ch]);
      check("final_tap", phys[ch], ctr_exp[ch]);
      err_sticky = err_sticky | err_exp[ch];
      check("tap_error", tap_error, err_sticky);
      last = ch; post_chan = 1'b1; chans++;
      inc_n = 0; dec_n = 0;
      ch = (ch + 1) % 8;
      if (chans == 8) begin
        calib_done = 1'b1;
        done_cyc   = cyc + 4;
      end else begin
        exp_chan_cyc = cyc + 4 + bit_cycles(ch);
      end
    end
    dq_data = dq_at(pats[ch], phys[ch]);
    if (cyc == glitch_at) dq_data = ~dq_data;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
      if (track) tick();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && !done_m; i++) cycles(1);
    check("done_reached", done_m, 1);
    cycles(3);
  endtask

  function automatic logic [14:0] all_outs();
    return {ctrl_calib_start, dlyinc, dlyce, chan_done, bit_cnt, center_tap, tap_calib_done, tap_error};
  endfunction

  initial begin
    int quiet;
    reset = 1'b1; calib_start = 1'b0; dq_data = 1'b0; calib_done = 1'b0;
    #1;
    check("reset_outs", all_outs(), 0);
    cycles(3);
    reset = 1'b0;

    // Run 1: the three documented eyes, then five random bits.
    pats[0] = '{1'b0, 10, 30};
    pats[1] = '{1'b1, 40, 0};
    pats[2] = '{1'b1, 0, 0};
    for (int k = 3; k < 8; k++) pats[k] = rand_pat();
    prepare();
    check("model_center_a", ctr_exp[0], 20);
    check("model_dec_a", tend[0] - ctr_exp[0], 10);
    check("model_center_b", ctr_exp[1], 51);
    check("model_dec_b", tend[1] - ctr_exp[1], 12);
    check("model_center_c", ctr_exp[2], 31);
    check("model_dec_c", tend[2] - ctr_exp[2], 32);
    check("model_err_c", err_exp[2], 1);
    calib_start = 1'b1;
    wait_done();
    check("done_bit_cnt", bit_cnt, 0);
    check("done_flag", tap_calib_done, 1);
    check("done_ctrl", ctrl_calib_start, 0);
    check("done_tap_error", tap_error, 1);
    calib_start = 1'b0;
    cycles(3);
    calib_start = 1'b1;
    cycles(10);
    check("done_holds", tap_calib_done, 1);

    // Run 2: random eyes, start request is a single-cycle pulse.
    calib_start = 1'b0;
    track = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_after_done", all_outs(), 0);
    cycles(2);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) pats[k] = rand_pat();
    prepare();
    calib_start = 1'b1;
    cycles(1);
    calib_start = 1'b0;
    wait_done();
    check("run2_done", tap_calib_done, 1);

    // Run 3: reset while backing off toward the centre.
    track = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) pats[k] = '{1'b0, 10, 30};
    prepare();
    calib_start = 1'b1;
    for (int i = 0; i < 5000 && !(dlyce && !dlyinc); i++) cycles(1);
    check("dec_seen", dlyce & ~dlyinc, 1);
    track = 1'b0;
    #1 reset = 1'b1;
    calib_start = 1'b0;
    #1 check("reset_in_dec", all_outs(), 0);
    cycles(2);
    reset = 1'b0;
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      quiet += int'(dlyce | ctrl_calib_start | chan_done);
    end
    check("quiet_after_reset", quiet, 0);
    calib_start = 1'b1;
    cycles(1);
    check("idle_restart", ctrl_calib_start, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
